udp_vid_pack: RTL and testbench

- Sits directly downstream of the UDP receive buffer, which emits vid_vs/vid_de/vid_data (one 16-bit pixel per vid_de beat, on vid_clk).
- Tracks pixel and line position, and packs 8 consecutive pixels into one 128-bit word for the frame-buffer write FIFO.
- Flags frames that are short and words that are dropped because the FIFO is full.
- The video stream cannot be stalled, so this block has no backpressure towards the video side.

---
 rtl/udp_vid_pack.sv | 148 ++++++++++++++
 tb/tb_udp_vid_pack.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_vid_pack.sv
// Packs 8 consecutive 16-bit pixels into 128-bit frame-buffer words and tracks frame position.
// Optional running pixel sum output enabled by defining UDP_VID_PACK_SUM_EN.
module udp_vid_pack #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic         vid_clk,
    input  logic         rstn,
    input  logic         vid_vs,
    input  logic         vid_de,
    input  logic [15:0]  vid_data,
    input  logic         wr_full,
    output logic         wr_en,
    output logic [127:0] wr_data,
    output logic         frame_start,
    output logic         frame_done,
    output logic [10:0]  pix_x,
    output logic [9:0]   line_y,
    output logic         err_short,
    output logic         err_ovf
`ifdef UDP_VID_PACK_SUM_EN
    ,
    output logic [31:0]  frame_sum
`endif
);

    generate
        if (H_ACTIVE > 2048 || V_ACTIVE > 1024 || (H_ACTIVE % 8) != 0) begin : g_bad_cfg
            $error("udp_vid_pack: H_ACTIVE must be a multiple of 8 and <= 2048, V_ACTIVE <= 1024");
        end
    endgenerate

    localparam logic [10:0] H_LAST = 11'(H_ACTIVE - 1);
    localparam logic [9:0]  V_LAST = 10'(V_ACTIVE - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_DONE} state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [2:0]     r_lane_cnt;
    logic [15:0]    r_lane [0:6];
    logic [10:0]    r_pix_x;
    logic [9:0]     r_line_y;
    logic           r_wr_en;
    logic [127:0]   r_wr_data;
    logic           r_frame_start;
    logic           r_frame_done;
    logic           r_err_short;
    logic           r_err_ovf;

    logic           w_pix_acc;
    logic           w_last_pix;
    logic           w_word_done;

    // vid_vs always wins over a coincident pixel.
    assign w_pix_acc   = (r_state == ST_ACTIVE) && vid_de && !vid_vs;
    assign w_last_pix  = (r_pix_x == H_LAST) && (r_line_y == V_LAST);
    assign w_word_done = w_pix_acc && (r_lane_cnt == 3'd7);

    // NOTE: next-state defaults to the current state first so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (vid_vs) w_state_nxt = ST_ACTIVE;
            ST_ACTIVE: if (!vid_vs && w_pix_acc && w_last_pix) w_state_nxt = ST_DONE;
            ST_DONE:   if (vid_vs) w_state_nxt = ST_ACTIVE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge vid_clk or negedge rstn) begin
        if (!rstn) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // NOTE: the lane buffer carries no reset; a cleared lane counter already discards stale lanes.
    always_ff @(posedge vid_clk) begin
        if (w_pix_acc && r_lane_cnt != 3'd7) r_lane[r_lane_cnt] <= vid_data;
    end

    always_ff @(posedge vid_clk or negedge rstn) begin
        if (!rstn) begin
            r_lane_cnt    <= 3'd0;
            r_pix_x       <= 11'd0;
            r_line_y      <= 10'd0;
            r_wr_en       <= 1'b0;
            r_wr_data     <= 128'd0;
            r_frame_start <= 1'b0;
            r_frame_done  <= 1'b0;
            r_err_short   <= 1'b0;
            r_err_ovf     <= 1'b0;
        end else begin
            r_wr_en       <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_done  <= 1'b0;
            r_err_short   <= 1'b0;
            if (vid_vs) begin
                r_frame_start <= 1'b1;
                r_err_short   <= (r_state == ST_ACTIVE);
                r_lane_cnt    <= 3'd0;
                r_pix_x       <= 11'd0;
                r_line_y      <= 10'd0;
                r_err_ovf     <= 1'b0;
            end else if (w_pix_acc) begin
                r_lane_cnt <= r_lane_cnt + 3'd1;
                // The final pixel leaves the position parked on the last column/line.
                if (!w_last_pix) begin
                    if (r_pix_x == H_LAST) begin
                        r_pix_x  <= 11'd0;
                        r_line_y <= r_line_y + 10'd1;
                    end else begin
                        r_pix_x <= r_pix_x + 11'd1;
                    end
                end
                if (w_word_done) begin
                    r_wr_en      <= !wr_full;
                    r_frame_done <= w_last_pix;
                    if (wr_full) r_err_ovf <= 1'b1;
                    else r_wr_data <= {vid_data, r_lane[6], r_lane[5], r_lane[4],
                                       r_lane[3], r_lane[2], r_lane[1], r_lane[0]};
                end
            end
        end
    end

`ifdef UDP_VID_PACK_SUM_EN
    logic [31:0] r_frame_sum;

    always_ff @(posedge vid_clk or negedge rstn) begin
        if (!rstn)          r_frame_sum <= 32'd0;
        else if (vid_vs)    r_frame_sum <= 32'd0;
        else if (w_pix_acc) r_frame_sum <= r_frame_sum + {16'd0, vid_data};
    end

    assign frame_sum = r_frame_sum;
`endif

    assign wr_en       = r_wr_en;
    assign wr_data     = r_wr_data;
    assign frame_start = r_frame_start;
    assign frame_done  = r_frame_done;
    assign pix_x       = r_pix_x;
    assign line_y      = r_line_y;
    assign err_short   = r_err_short;
    assign err_ovf     = r_err_ovf;

endmodule

// File: tb/tb_udp_vid_pack.sv
// Directed testbench for udp_vid_pack with a 16x2 frame; define UDP_VID_PACK_SUM_EN to cover frame_sum.
module tb_udp_vid_pack;

    logic         clk;
    logic         rstn;
    logic         vid_vs;
    logic         vid_de;
    logic [15:0]  vid_data;
    logic         wr_full;
    logic         wr_en;
    logic [127:0] wr_data;
    logic         frame_start;
    logic         frame_done;
    logic [10:0]  pix_x;
    logic [9:0]   line_y;
    logic         err_short;
    logic         err_ovf;
`ifdef UDP_VID_PACK_SUM_EN
    logic [31:0]  frame_sum;
`endif

    int total = 0;
    int bad   = 0;

    logic [127:0] words [$];
    int n_wr, n_fd, n_fd_wr, n_short, n_start;

    udp_vid_pack #(.H_ACTIVE(16), .V_ACTIVE(2)) dut (
        .vid_clk     (clk),
        .rstn        (rstn),
        .vid_vs      (vid_vs),
        .vid_de      (vid_de),
        .vid_data    (vid_data),
        .wr_full     (wr_full),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .pix_x       (pix_x),
        .line_y      (line_y),
        .err_short   (err_short),
        .err_ovf     (err_ovf)
`ifdef UDP_VID_PACK_SUM_EN
        ,
        .frame_sum   (frame_sum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected packed word for pixels base..base+7, pixel base in the low lane.
    function automatic logic [127:0] exp_word(input int base);
        logic [127:0] w;
        w = '0;
        for (int i = 0; i < 8; i++) w[16*i +: 16] = 16'(base + i);
        return w;
    endfunction

    task automatic clear_stats();
        words.delete();
        n_wr = 0; n_fd = 0; n_fd_wr = 0; n_short = 0; n_start = 0;
    endtask

    // One clock; outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (wr_en) begin
            words.push_back(wr_data);
            n_wr++;
        end
        if (frame_done) begin
            n_fd++;
            if (wr_en) n_fd_wr++;
        end
        if (err_short)   n_short++;
        if (frame_start) n_start++;
    endtask

    task automatic pix(input logic [15:0] d, input logic full);
        vid_de = 1'b1; vid_data = d; wr_full = full;
        step();
        vid_de = 1'b0; wr_full = 1'b0;
    endtask

    task automatic idle();
        step();
    endtask

    task automatic vs();
        vid_vs = 1'b1;
        step();
        vid_vs = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; vid_vs = 1'b0; vid_de = 1'b0; vid_data = '0; wr_full = 1'b0;
        #12;
        total++; if (wr_en !== 1'b0)          begin bad++; $display("FAIL reset_wr_en got=%b want=0", wr_en); end
        total++; if (wr_data !== 128'd0)      begin bad++; $display("FAIL reset_wr_data got=%h want=0", wr_data); end
        total++; if (frame_start !== 1'b0)    begin bad++; $display("FAIL reset_frame_start got=%b want=0", frame_start); end
        total++; if (frame_done !== 1'b0)     begin bad++; $display("FAIL reset_frame_done got=%b want=0", frame_done); end
        total++; if (pix_x !== 11'd0)         begin bad++; $display("FAIL reset_pix_x got=%0d want=0", pix_x); end
        total++; if (line_y !== 10'd0)        begin bad++; $display("FAIL reset_line_y got=%0d want=0", line_y); end
        total++; if (err_short !== 1'b0)      begin bad++; $display("FAIL reset_err_short got=%b want=0", err_short); end
        total++; if (err_ovf !== 1'b0)        begin bad++; $display("FAIL reset_err_ovf got=%b want=0", err_ovf); end
`ifdef UDP_VID_PACK_SUM_EN
        total++; if (frame_sum !== 32'd0)     begin bad++; $display("FAIL reset_frame_sum got=%h want=0", frame_sum); end
`endif
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_ignore_idle();
        clear_stats();
        for (int i = 1; i <= 8; i++) pix(16'(i), 1'b0);
        idle();
        total++; if (n_wr !== 0)        begin bad++; $display("FAIL idle_no_wr got=%0d want=0", n_wr); end
        total++; if (pix_x !== 11'd0)   begin bad++; $display("FAIL idle_pix_x got=%0d want=0", pix_x); end
        total++; if (line_y !== 10'd0)  begin bad++; $display("FAIL idle_line_y got=%0d want=0", line_y); end
    endtask

    task automatic test_normal();
        clear_stats();
        vs();
        total++; if (frame_start !== 1'b1) begin bad++; $display("FAIL normal_frame_start got=%b want=1", frame_start); end
        total++; if (err_short !== 1'b0)   begin bad++; $display("FAIL normal_vs_short got=%b want=0", err_short); end
        for (int i = 1; i <= 32; i++) begin
            pix(16'(i), 1'b0);
            total++;
            if (wr_en !== ((i % 8) == 0)) begin bad++; $display("FAIL normal_wr_en_pix%0d got=%b want=%b", i, wr_en, (i % 8) == 0); end
            if (i == 16) begin
                total++; if (pix_x !== 11'd0 || line_y !== 10'd1)
                    begin bad++; $display("FAIL normal_line_wrap got=%0d/%0d want=0/1", pix_x, line_y); end
            end
        end
        idle();
        total++; if (n_wr !== 4) begin bad++; $display("FAIL normal_word_count got=%0d want=4", n_wr); end
        for (int k = 0; k < 4; k++) begin
            total++;
            if (((words.size() > k) ? words[k] : 128'd0) !== exp_word(8*k + 1))
                begin bad++; $display("FAIL normal_word%0d got=%h want=%h", k, (words.size() > k) ? words[k] : 128'd0, exp_word(8*k + 1)); end
        end
        total++; if (n_fd !== 1 || n_fd_wr !== 1) begin bad++; $display("FAIL normal_frame_done got=%0d/%0d want=1/1", n_fd, n_fd_wr); end
        total++; if (n_short !== 0 || err_ovf !== 1'b0) begin bad++; $display("FAIL normal_errors got=%0d/%b want=0/0", n_short, err_ovf); end
        total++; if (pix_x !== 11'd15 || line_y !== 10'd1) begin bad++; $display("FAIL normal_final_pos got=%0d/%0d want=15/1", pix_x, line_y); end
`ifdef UDP_VID_PACK_SUM_EN
        total++; if (frame_sum !== 32'h210) begin bad++; $display("FAIL normal_frame_sum got=%h want=00000210", frame_sum); end
`endif
    endtask

    task automatic test_ignore_done();
        clear_stats();
        for (int i = 0; i < 8; i++) pix(16'hFFFF, 1'b0);
        idle();
        total++; if (n_wr !== 0) begin bad++; $display("FAIL done_no_wr got=%0d want=0", n_wr); end
        total++; if (pix_x !== 11'd15 || line_y !== 10'd1) begin bad++; $display("FAIL done_pos_hold got=%0d/%0d want=15/1", pix_x, line_y); end
        vid_vs = 1'b1; vid_de = 1'b1; vid_data = 16'h00AA;
        step();
        vid_vs = 1'b0; vid_de = 1'b0;
        total++; if (frame_start !== 1'b1 || pix_x !== 11'd0) begin bad++; $display("FAIL vs_de_start got=%b/%0d want=1/0", frame_start, pix_x); end
        clear_stats();
        for (int i = 1; i <= 32; i++) pix(16'(i), 1'b0);
        total++; if (n_wr !== 4) begin bad++; $display("FAIL vs_de_word_count got=%0d want=4", n_wr); end
        total++;
        if (((words.size() > 0) ? words[0] : 128'd0) !== exp_word(1))
            begin bad++; $display("FAIL vs_de_first_word got=%h want=%h", (words.size() > 0) ? words[0] : 128'd0, exp_word(1)); end
    endtask

    task automatic test_gapped();
        clear_stats();
        vs();
        for (int i = 1; i <= 32; i++) begin
            pix(16'(i), 1'b0);
            total++;
            if (wr_en !== ((i % 8) == 0)) begin bad++; $display("FAIL gap_wr_en_pix%0d got=%b want=%b", i, wr_en, (i % 8) == 0); end
            idle();
            total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL gap_wr_en_idle%0d got=%b want=0", i, wr_en); end
        end
        total++; if (n_wr !== 4) begin bad++; $display("FAIL gap_word_count got=%0d want=4", n_wr); end
        for (int k = 0; k < 4; k++) begin
            total++;
            if (((words.size() > k) ? words[k] : 128'd0) !== exp_word(8*k + 1))
                begin bad++; $display("FAIL gap_word%0d got=%h want=%h", k, (words.size() > k) ? words[k] : 128'd0, exp_word(8*k + 1)); end
        end
        total++; if (n_fd !== 1) begin bad++; $display("FAIL gap_frame_done got=%0d want=1", n_fd); end
    endtask

    task automatic test_overflow();
        clear_stats();
        vs();
        for (int i = 1; i <= 32; i++) begin
            pix(16'(i), i == 16);
            if (i == 16) begin
                total++; if (wr_en !== 1'b0 || err_ovf !== 1'b1) begin bad++; $display("FAIL ovf_drop got=%b/%b want=0/1", wr_en, err_ovf); end
                total++; if (wr_data !== exp_word(1)) begin bad++; $display("FAIL ovf_wr_data_hold got=%h want=%h", wr_data, exp_word(1)); end
            end
        end
        total++; if (n_wr !== 3) begin bad++; $display("FAIL ovf_word_count got=%0d want=3", n_wr); end
        total++;
        if (words.size() != 3 || words[0] !== exp_word(1) || words[1] !== exp_word(17) || words[2] !== exp_word(25))
            begin bad++; $display("FAIL ovf_words got_count=%0d want=3 (words 1,3,4)", words.size()); end
        total++; if (n_fd !== 1 || n_fd_wr !== 1) begin bad++; $display("FAIL ovf_frame_done got=%0d/%0d want=1/1", n_fd, n_fd_wr); end
        total++; if (err_ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b want=1", err_ovf); end
`ifdef UDP_VID_PACK_SUM_EN
        total++; if (frame_sum !== 32'h210) begin bad++; $display("FAIL ovf_frame_sum got=%h want=00000210", frame_sum); end
`endif
        vs();
        total++; if (err_ovf !== 1'b0 || err_short !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b/%b want=0/0", err_ovf, err_short); end
    endtask

    task automatic test_short();
        clear_stats();
        vs();
        for (int i = 1; i <= 12; i++) pix(16'(i), 1'b0);
        vs();
        total++; if (frame_start !== 1'b1 || err_short !== 1'b1) begin bad++; $display("FAIL short_pulses got=%b/%b want=1/1", frame_start, err_short); end
        total++; if (n_wr !== 1) begin bad++; $display("FAIL short_word_count got=%0d want=1", n_wr); end
        total++; if (pix_x !== 11'd0 || line_y !== 10'd0) begin bad++; $display("FAIL short_pos_clear got=%0d/%0d want=0/0", pix_x, line_y); end
        clear_stats();
        for (int i = 1; i <= 32; i++) pix(16'(i), 1'b0);
        idle();
        total++; if (n_wr !== 4 || n_fd !== 1) begin bad++; $display("FAIL short_next_frame got=%0d/%0d want=4/1", n_wr, n_fd); end
        total++;
        if (((words.size() > 0) ? words[0] : 128'd0) !== exp_word(1))
            begin bad++; $display("FAIL short_next_first got=%h want=%h", (words.size() > 0) ? words[0] : 128'd0, exp_word(1)); end
    endtask

    task automatic test_reset_midframe();
        clear_stats();
        vs();
        for (int i = 1; i <= 5; i++) pix(16'(i), 1'b0);
        total++; if (pix_x !== 11'd5) begin bad++; $display("FAIL mid_pre_pix_x got=%0d want=5", pix_x); end
        rstn = 1'b0;
        #1;
        total++; if (pix_x !== 11'd0 || line_y !== 10'd0) begin bad++; $display("FAIL mid_rst_pos got=%0d/%0d want=0/0", pix_x, line_y); end
        total++; if (wr_data !== 128'd0 || wr_en !== 1'b0) begin bad++; $display("FAIL mid_rst_wr got=%h/%b want=0/0", wr_data, wr_en); end
        total++; if (frame_start !== 1'b0 || frame_done !== 1'b0 || err_short !== 1'b0 || err_ovf !== 1'b0)
            begin bad++; $display("FAIL mid_rst_flags got=%b%b%b%b want=0000", frame_start, frame_done, err_short, err_ovf); end
        @(negedge clk);
        rstn = 1'b1;
        clear_stats();
        vs();
        for (int i = 1; i <= 32; i++) pix(16'(i), 1'b0);
        idle();
        total++; if (n_wr !== 4 || n_fd !== 1) begin bad++; $display("FAIL mid_clean_frame got=%0d/%0d want=4/1", n_wr, n_fd); end
        total++;
        if (((words.size() > 0) ? words[0] : 128'd0) !== exp_word(1))
            begin bad++; $display("FAIL mid_clean_first got=%h want=%h", (words.size() > 0) ? words[0] : 128'd0, exp_word(1)); end
        total++; if (pix_x !== 11'd15 || line_y !== 10'd1) begin bad++; $display("FAIL mid_clean_pos got=%0d/%0d want=15/1", pix_x, line_y); end
    endtask

    initial begin
        test_reset();
        test_ignore_idle();
        test_normal();
        test_ignore_done();
        test_gapped();
        test_overflow();
        test_short();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
